// File: rtl/pipe_skid_stage.sv
// Two-entry elastic pipeline register (main + skid) with valid/ready on both sides.
// Every output is a flop, so ready never sees a combinational path from the consumer.
module pipe_skid_stage #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         rstN,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] main_q, main_d;
    logic [N-1:0] skid_q, skid_d;
    logic         in_fire, out_fire;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over everything; a beat accepted this cycle is dropped.
        if (flush) state_d = EMPTY;
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Data registers carry no reset; contents only matter when marked valid.
    always_ff @(posedge clock) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign count     = state_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus random valid/ready traffic,
// checked against a plain FIFO-queue model of at most two beats.
module tb_pipe_skid_stage;

    localparam int N = 8;

    logic         clock = 1'b0;
    logic         rstN;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   count;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] mq[$];   // model contents, head first
    logic [N-1:0] obs[$];  // beats the DUT delivered
    logic [N-1:0] exp_q[$];

    pipe_skid_stage #(.N(N)) dut (
        .clock    (clock),
        .rstN     (rstN),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(mq.size()));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
        if (mq.size() > 0) chk({tag, "_out_data"}, 32'(out_data), 32'(mq[0]));
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cyc(input bit iv, input logic [N-1:0] d, input bit ordy, input bit fl,
                       input string tag, output bit acc);
        bit in_f, out_f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk({tag, "_in_ready_comb"}, 32'(in_ready), 32'(mq.size() < 2));
        in_f  = iv && (mq.size() < 2);
        out_f = (mq.size() > 0) && ordy;
        if (out_valid && out_ready) obs.push_back(out_data);
        @(posedge clock);
        if (out_f) void'(mq.pop_front());
        if (fl) mq.delete();
        else if (in_f) mq.push_back(d);
        acc = in_f && !fl;
        @(negedge clock);
        chk_outs(tag);
    endtask

    initial begin
        bit acc;
        int accepted;
        int cycles;
        bit hold_v;
        logic [N-1:0] hold_d;

        rstN = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Reset then idle
        repeat (2) begin
            @(negedge clock);
            chk("rst_count", 32'(count), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_in_ready", 32'(in_ready), 1);
        end
        rstN = 1'b1;
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, "idle", acc);

        // Streaming 0x00..0x0F
        obs.delete();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, N'(i), 1'b1, 1'b0, "stream", acc);
            chk("stream_count1", 32'(count), 1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0, "stream_drain", acc);
        chk("stream_len", obs.size(), 16);
        for (int i = 0; i < 16 && i < obs.size(); i++) chk("stream_beat", 32'(obs[i]), i);

        // Back-pressure
        obs.delete();
        cyc(1'b1, 8'hA1, 1'b0, 1'b0, "bp", acc);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0, "bp", acc);
        cyc(1'b1, 8'hA3, 1'b0, 1'b0, "bp", acc);
        chk("bp_full_count", 32'(count), 2);
        chk("bp_full_in_ready", 32'(in_ready), 0);
        chk("bp_full_head", 32'(out_data), 32'h A1);
        cyc(1'b1, 8'hA3, 1'b1, 1'b0, "bp_rel", acc);
        chk("bp_restart_in_ready", 32'(in_ready), 1);
        cyc(1'b1, 8'hA3, 1'b1, 1'b0, "bp_rel", acc);
        cyc(1'b0, '0, 1'b1, 1'b0, "bp_rel", acc);
        chk("bp_len", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("bp_beat0", 32'(obs[0]), 32'h A1);
            chk("bp_beat1", 32'(obs[1]), 32'h A2);
            chk("bp_beat2", 32'(obs[2]), 32'h A3);
        end

        // Flush collisions
        obs.delete();
        cyc(1'b1, 8'h11, 1'b0, 1'b0, "fl", acc);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, "fl", acc);
        cyc(1'b0, '0, 1'b0, 1'b1, "fl_novalid", acc);
        chk("fl1_count", 32'(count), 0);
        chk("fl1_out_valid", 32'(out_valid), 0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0, "fl", acc);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, "fl", acc);
        cyc(1'b1, 8'h33, 1'b0, 1'b1, "fl_valid", acc);
        chk("fl2_count", 32'(count), 0);
        chk("fl2_out_valid", 32'(out_valid), 0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0, "fl", acc);
        cyc(1'b1, 8'h44, 1'b0, 1'b1, "fl_busy", acc);
        chk("fl3_count", 32'(count), 0);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, "fl_after", acc);
        chk("fl_nothing_out", obs.size(), 0);

        // Asynchronous reset while FULL
        cyc(1'b1, 8'h55, 1'b0, 1'b0, "ar", acc);
        cyc(1'b1, 8'h66, 1'b0, 1'b0, "ar", acc);
        in_valid = 1'b0;
        #2 rstN = 1'b0;
        #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_out_valid", 32'(out_valid), 0);
        chk("ar_in_ready", 32'(in_ready), 1);
        mq.delete();
        @(negedge clock);
        rstN = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b0, "ar_after", acc);

        // Random traffic, ~30% stall each side
        obs.delete();
        exp_q.delete();
        accepted = 0;
        cycles = 0;
        hold_v = 1'b0;
        hold_d = '0;
        while (accepted < 1000 && cycles < 5000) begin
            bit iv;
            logic [N-1:0] d;
            if (hold_v) begin
                iv = 1'b1; d = hold_d;
            end else begin
                iv = ($urandom_range(99) >= 30);
                d  = N'($urandom);
            end
            cyc(iv, d, ($urandom_range(99) >= 30), 1'b0, "rnd", acc);
            if (acc) begin
                exp_q.push_back(d);
                accepted++;
            end
            hold_v = iv && !acc;
            hold_d = d;
            cycles++;
        end
        chk("rnd_budget", accepted, 1000);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, "rnd_drain", acc);
        chk("rnd_len", obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            chk("rnd_beat", 32'(obs[i]), 32'(exp_q[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
